// File: rtl/hh_ion_current_sequencer_pkg.sv
// Shared fixed-point constants, FSM state type and saturation helper for the
// Hodgkin-Huxley ionic-current sequencer.
package hh_fixed_pkg;

    localparam int unsigned FRAC  = 8;
    localparam int unsigned WIDTH = 16;

    localparam int unsigned STEP_W    = 4;
    localparam logic [STEP_W-1:0] LAST_STEP = 4'd9;

    localparam logic signed [WIDTH-1:0] DEF_G_NA = 16'sd30720;
    localparam logic signed [WIDTH-1:0] DEF_G_K  = 16'sd9216;
    localparam logic signed [WIDTH-1:0] DEF_G_L  = 16'sd77;
    localparam logic signed [WIDTH-1:0] DEF_E_NA = 16'sd12800;
    localparam logic signed [WIDTH-1:0] DEF_E_K  = -16'sd19712;
    localparam logic signed [WIDTH-1:0] DEF_E_L  = -16'sd13926;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SUM  = 2'd2
    } state_e;

    // Clamp any sign-extended 17/18/32-bit intermediate into the 16-bit range.
    function automatic logic signed [WIDTH-1:0] sat16(input logic signed [31:0] x);
        if (x > 32'sd32767) begin
            return 16'sh7FFF;
        end else if (x < -32'sd32768) begin
            return 16'sh8000;
        end else begin
            return x[WIDTH-1:0];
        end
    endfunction

endpackage

// File: rtl/hh_ion_current_sequencer_if.sv
// Request/result bundle between the gating updaters, this sequencer and the integrator.
interface hh_ion_current_sequencer_if;
    import hh_fixed_pkg::*;

    logic                    start;
    logic signed [WIDTH-1:0] V;
    logic signed [WIDTH-1:0] m;
    logic signed [WIDTH-1:0] h;
    logic signed [WIDTH-1:0] n;
    logic                    busy;
    logic                    done;
    logic signed [WIDTH-1:0] I_NA;
    logic signed [WIDTH-1:0] I_K;
    logic signed [WIDTH-1:0] I_L;
    logic signed [WIDTH-1:0] I_ION;

    modport master (
        output start, V, m, h, n,
        input  busy, done, I_NA, I_K, I_L, I_ION
    );

    modport slave (
        input  start, V, m, h, n,
        output busy, done, I_NA, I_K, I_L, I_ION
    );

endinterface

// File: rtl/hh_fx_mul.sv
// Combinational fixed-point multiply: full product, floor shift by FRAC, saturate.
module hh_fx_mul
    import hh_fixed_pkg::*;
#(
    parameter int unsigned FRAC = hh_fixed_pkg::FRAC
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] y_c
);

    logic signed [31:0] prod;
    logic signed [31:0] shifted;

    assign prod    = 32'(a) * 32'(b);
    assign shifted = prod >>> FRAC;
    assign y_c     = sat16(shifted);

endmodule

// File: rtl/hh_ion_current_sequencer.sv
// Step-sequenced evaluation of I_NA, I_K, I_L and I_ION through one shared multiplier.
module hh_ion_current_sequencer
    import hh_fixed_pkg::*;
#(
    parameter int unsigned             FRAC = hh_fixed_pkg::FRAC,
    parameter logic signed [WIDTH-1:0] G_NA = DEF_G_NA,
    parameter logic signed [WIDTH-1:0] G_K  = DEF_G_K,
    parameter logic signed [WIDTH-1:0] G_L  = DEF_G_L,
    parameter logic signed [WIDTH-1:0] E_NA = DEF_E_NA,
    parameter logic signed [WIDTH-1:0] E_K  = DEF_E_K,
    parameter logic signed [WIDTH-1:0] E_L  = DEF_E_L
) (
    input  logic                          clk,
    input  logic                          rst,
    hh_ion_current_sequencer_if.slave     bus
);

    state_e              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic signed [WIDTH-1:0] v_q, v_d, m_q, m_d, h_q, h_d, n_q, n_d;
    logic signed [WIDTH-1:0] t_q, t_d, na_q, na_d, k_q, k_d, l_q, l_d;
    logic signed [WIDTH-1:0] i_na_q, i_na_d, i_k_q, i_k_d, i_l_q, i_l_d, i_ion_q, i_ion_d;
    logic                busy_q, busy_d, done_q, done_d;

    logic signed [16:0]      diff_na_c, diff_k_c, diff_l_c;
    logic signed [WIDTH-1:0] dv_na_c, dv_k_c, dv_l_c;
    logic signed [17:0]      sum_c;
    logic signed [WIDTH-1:0] op_a_c, op_b_c, mul_y_c;

    // Driving-force terms, widened by one bit so they cannot wrap before clamping.
    assign diff_na_c = 17'(v_q) - 17'(E_NA);
    assign diff_k_c  = 17'(v_q) - 17'(E_K);
    assign diff_l_c  = 17'(v_q) - 17'(E_L);
    assign dv_na_c   = sat16(32'(diff_na_c));
    assign dv_k_c    = sat16(32'(diff_k_c));
    assign dv_l_c    = sat16(32'(diff_l_c));
    assign sum_c     = 18'(na_q) + 18'(k_q) + 18'(l_q);

    hh_fx_mul #(.FRAC(FRAC)) u_mul (
        .a   (op_a_c),
        .b   (op_b_c),
        .y_c (mul_y_c)
    );

    // Operand schedule: m^3*h*G_NA*dV, n^4*G_K*dV, G_L*dV.
    always_comb begin
        op_a_c = '0;
        op_b_c = '0;
        case (step_q)
            4'd0:    begin op_a_c = m_q;  op_b_c = m_q;     end
            4'd1:    begin op_a_c = t_q;  op_b_c = m_q;     end
            4'd2:    begin op_a_c = t_q;  op_b_c = h_q;     end
            4'd3:    begin op_a_c = t_q;  op_b_c = G_NA;    end
            4'd4:    begin op_a_c = t_q;  op_b_c = dv_na_c; end
            4'd5:    begin op_a_c = n_q;  op_b_c = n_q;     end
            4'd6:    begin op_a_c = t_q;  op_b_c = t_q;     end
            4'd7:    begin op_a_c = t_q;  op_b_c = G_K;     end
            4'd8:    begin op_a_c = t_q;  op_b_c = dv_k_c;  end
            4'd9:    begin op_a_c = G_L;  op_b_c = dv_l_c;  end
            default: begin op_a_c = '0;   op_b_c = '0;      end
        endcase
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        v_d     = v_q;
        m_d     = m_q;
        h_d     = h_q;
        n_d     = n_q;
        t_d     = t_q;
        na_d    = na_q;
        k_d     = k_q;
        l_d     = l_q;
        i_na_d  = i_na_q;
        i_k_d   = i_k_q;
        i_l_d   = i_l_q;
        i_ion_d = i_ion_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    v_d     = bus.V;
                    m_d     = bus.m;
                    h_d     = bus.h;
                    n_d     = bus.n;
                    step_d  = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                case (step_q)
                    4'd4:    na_d = mul_y_c;
                    4'd8:    k_d  = mul_y_c;
                    4'd9:    l_d  = mul_y_c;
                    default: t_d  = mul_y_c;
                endcase
                if (step_q == LAST_STEP) begin
                    state_d = SUM;
                end else begin
                    step_d = step_q + 4'd1;
                end
            end
            SUM: begin
                i_na_d  = na_q;
                i_k_d   = k_q;
                i_l_d   = l_q;
                i_ion_d = sat16(32'(sum_c));
                done_d  = 1'b1;
                busy_d  = 1'b0;
                step_d  = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= '0;
            v_q     <= '0;
            m_q     <= '0;
            h_q     <= '0;
            n_q     <= '0;
            t_q     <= '0;
            na_q    <= '0;
            k_q     <= '0;
            l_q     <= '0;
            i_na_q  <= '0;
            i_k_q   <= '0;
            i_l_q   <= '0;
            i_ion_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            v_q     <= v_d;
            m_q     <= m_d;
            h_q     <= h_d;
            n_q     <= n_d;
            t_q     <= t_d;
            na_q    <= na_d;
            k_q     <= k_d;
            l_q     <= l_d;
            i_na_q  <= i_na_d;
            i_k_q   <= i_k_d;
            i_l_q   <= i_l_d;
            i_ion_q <= i_ion_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.I_NA  = i_na_q;
    assign bus.I_K   = i_k_q;
    assign bus.I_L   = i_l_q;
    assign bus.I_ION = i_ion_q;

endmodule

// File: tb/tb_hh_ion_current_sequencer.sv
// Directed bench: a unity-parameter instance and a default-parameter instance run in lockstep.
module tb_hh_ion_current_sequencer;

    logic clk = 1'b0;
    logic rst;

    hh_ion_current_sequencer_if bus_u ();
    hh_ion_current_sequencer_if bus_d ();

    hh_ion_current_sequencer #(
        .FRAC(8),
        .G_NA(16'sd256), .G_K(16'sd256), .G_L(16'sd256),
        .E_NA(16'sd0),   .E_K(16'sd0),   .E_L(16'sd0)
    ) dut_u (
        .clk (clk),
        .rst (rst),
        .bus (bus_u.slave)
    );

    hh_ion_current_sequencer dut_d (
        .clk (clk),
        .rst (rst),
        .bus (bus_d.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic signed [15:0] v, m, h, n;
        logic signed [15:0] u_na, u_k, u_l, u_ion;
        logic               chk_d;
        logic signed [15:0] d_na, d_k, d_l, d_ion;
    } vec_t;

    localparam int NVEC = 6;
    vec_t vecs [NVEC];

    int checks = 0;
    int errors = 0;
    int prev_u [4];

    function automatic vec_t mk(int v, int m, int h, int n,
                                int una, int uk, int ul, int uion,
                                logic cd, int dna, int dk, int dl, int dion);
        vec_t r;
        r.v = 16'(v);  r.m = 16'(m);  r.h = 16'(h);  r.n = 16'(n);
        r.u_na = 16'(una); r.u_k = 16'(uk); r.u_l = 16'(ul); r.u_ion = 16'(uion);
        r.chk_d = cd;
        r.d_na = 16'(dna); r.d_k = 16'(dk); r.d_l = 16'(dl); r.d_ion = 16'(dion);
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic s, input int v, input int m, input int h, input int n);
        bus_u.start = s; bus_u.V = 16'(v); bus_u.m = 16'(m); bus_u.h = 16'(h); bus_u.n = 16'(n);
        bus_d.start = s; bus_d.V = 16'(v); bus_d.m = 16'(m); bus_d.h = 16'(h); bus_d.n = 16'(n);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_u_out(input string nm, input int na, input int k, input int l, input int ion);
        chk({nm, " I_NA"},  int'(bus_u.I_NA),  na);
        chk({nm, " I_K"},   int'(bus_u.I_K),   k);
        chk({nm, " I_L"},   int'(bus_u.I_L),   l);
        chk({nm, " I_ION"}, int'(bus_u.I_ION), ion);
    endtask

    // One full transaction: accept, latency/busy/hold checks, results, single-cycle done.
    task automatic run_vec(input vec_t x, input string nm);
        int  lat;
        bit  got, busy_ok, hold_ok;
        drive(1'b1, int'(x.v), int'(x.m), int'(x.h), int'(x.n));
        tick();
        drive(1'b0, 3, -5, 7, -9);
        chk({nm, " busy after accept"}, int'(bus_u.busy), 1);
        lat = 0; got = 1'b0; busy_ok = 1'b1; hold_ok = 1'b1;
        while (lat < 20 && !got) begin
            tick();
            lat++;
            if (bus_u.done) begin
                got = 1'b1;
            end else begin
                if (!bus_u.busy) busy_ok = 1'b0;
                if (int'(bus_u.I_NA) != prev_u[0] || int'(bus_u.I_K) != prev_u[1] ||
                    int'(bus_u.I_L) != prev_u[2] || int'(bus_u.I_ION) != prev_u[3])
                    hold_ok = 1'b0;
            end
        end
        chk({nm, " latency"}, lat, 11);
        chk({nm, " busy during run"}, int'(busy_ok), 1);
        chk({nm, " outputs held during run"}, int'(hold_ok), 1);
        chk({nm, " busy at done"}, int'(bus_u.busy), 0);
        chk({nm, " done_d"}, int'(bus_d.done), 1);
        chk_u_out(nm, int'(x.u_na), int'(x.u_k), int'(x.u_l), int'(x.u_ion));
        if (x.chk_d) begin
            chk({nm, " dflt I_NA"},  int'(bus_d.I_NA),  int'(x.d_na));
            chk({nm, " dflt I_K"},   int'(bus_d.I_K),   int'(x.d_k));
            chk({nm, " dflt I_L"},   int'(bus_d.I_L),   int'(x.d_l));
            chk({nm, " dflt I_ION"}, int'(bus_d.I_ION), int'(x.d_ion));
        end
        tick();
        chk({nm, " done one cycle"}, int'(bus_u.done), 0);
        prev_u[0] = int'(x.u_na); prev_u[1] = int'(x.u_k);
        prev_u[2] = int'(x.u_l);  prev_u[3] = int'(x.u_ion);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  done_cnt, first_c, second_c, c, w;
        bit  quiet;

        vecs[0] = mk(512, 256, 256, 256,     512, 512, 512, 1536,        1'b1, -32768, 32767, 4342, 4341);
        vecs[1] = mk(256, 128, 256, 128,     32, 16, 256, 304,           1'b1, -32768, 32767, 4265, 4264);
        vecs[2] = mk(-25600, 256, 256, 256,  -25600, -25600, -25600, -32768, 1'b1, -32768, -32768, -3512, -32768);
        vecs[3] = mk(0, 0, 0, 0,             0, 0, 0, 0,                 1'b1, 0, 0, 4188, 4188);
        vecs[4] = mk(-1, 128, 128, 128,      -1, -1, -1, -3,             1'b0, 0, 0, 0, 0);
        vecs[5] = mk(32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 1'b1, 32767, 32767, 9855, 32767);
        for (int i = 0; i < 4; i++) prev_u[i] = 0;

        // Reset with start held high.
        rst = 1'b1;
        drive(1'b1, 512, 256, 256, 256);
        tick();
        tick();
        chk("reset busy", int'(bus_u.busy), 0);
        chk("reset done", int'(bus_u.done), 0);
        chk_u_out("reset", 0, 0, 0, 0);
        chk("reset dflt I_ION", int'(bus_d.I_ION), 0);

        rst = 1'b0;
        drive(1'b0, 512, 256, 256, 256);
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus_u.busy || bus_u.done || bus_d.busy || bus_d.done || bus_u.I_ION != 16'sd0)
                quiet = 1'b0;
        end
        chk("idle quiet 20 cycles", int'(quiet), 1);

        for (int i = 0; i < NVEC; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Start held high, V changing every cycle: back-to-back runs on captured V.
        done_cnt = 0; first_c = -1; second_c = -1;
        for (c = 0; c < 30; c++) begin
            drive(1'b1, 10 * c + 10, 256, 256, 256);
            tick();
            if (bus_u.done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    first_c = c;
                    chk_u_out("hs run1", 10, 10, 10, 30);
                end else if (done_cnt == 2) begin
                    second_c = c;
                    chk_u_out("hs run2", 130, 130, 130, 390);
                end
            end
        end
        chk("hs done count", done_cnt, 2);
        chk("hs first done cycle", first_c, 11);
        chk("hs second done cycle", second_c, 23);
        drive(1'b0, -7, 0, 0, 0);
        w = 0;
        while (w < 20 && !bus_u.done) begin
            tick();
            w++;
        end
        chk("hs third done cycle", 30 + w - 1, 35);
        chk_u_out("hs run3", 250, 250, 250, 750);
        tick();
        chk("hs idle after drain", int'(bus_u.busy), 0);

        // Abort at step 5, then a clean rerun.
        drive(1'b1, 512, 256, 256, 256);
        tick();
        drive(1'b0, 512, 256, 256, 256);
        for (int i = 0; i < 5; i++) tick();
        chk("abort busy before rst", int'(bus_u.busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort busy", int'(bus_u.busy), 0);
        chk("abort done", int'(bus_u.done), 0);
        chk_u_out("abort", 0, 0, 0, 0);
        quiet = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus_u.done || bus_u.busy) quiet = 1'b0;
        end
        chk("abort no late done", int'(quiet), 1);
        for (int i = 0; i < 4; i++) prev_u[i] = 0;
        run_vec(vecs[0], "rerun");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
